// File: rtl/axis_position_tracker_if.sv
// Sample stream carrying a tvalid/tdata pair between the ADC path, the position tracker and the DMA path.
// Valid/ready semantics: there is no tready. The consumer is always ready, so a beat transfers on every rising edge where tvalid is high.
interface axis_position_tracker_if #(
    parameter int DATA_W = 32
);
    logic              tvalid;
    logic [DATA_W-1:0] tdata;

    modport master (output tvalid, output tdata);
    modport slave  (input  tvalid, input  tdata);
endinterface

// File: rtl/axis_position_tracker.sv
// Hysteresis comparators, quadrature decoder and scaled position output, with three register stages.
// Optional macro POSITION_TRACKER_ERROR_CNT_EN adds a saturating count of illegal double transitions.
module axis_position_tracker #(
    parameter int S_AXIS_TDATA_WIDTH = 32,
    parameter int M_AXIS_TDATA_WIDTH = 32
) (
    input  logic                                  aclk,
    input  logic                                  areset,
    input  logic signed [S_AXIS_TDATA_WIDTH/2-1:0] lower_threshold,
    input  logic signed [S_AXIS_TDATA_WIDTH/2-1:0] upper_threshold,
    input  logic [4:0]                            log_scale,
    axis_position_tracker_if.slave                S_AXIS,
    axis_position_tracker_if.master               M_AXIS
`ifdef POSITION_TRACKER_ERROR_CNT_EN
    ,
    output logic [15:0]                           error_count
`endif
);
    localparam int HW = S_AXIS_TDATA_WIDTH / 2;
    localparam int PW = M_AXIS_TDATA_WIDTH;

    logic signed [HW-1:0] sample_a;
    logic signed [HW-1:0] sample_b;
    logic                 bit_a_q, bit_a_d;
    logic                 bit_b_q, bit_b_d;
    logic                 v1_q, v1_d;
    logic [1:0]           prev_q, prev_d;
    logic                 init_q, init_d;
    logic                 v2_q, v2_d;
    logic [PW-1:0]        pos_q, pos_d;
    logic [PW-1:0]        out_q, out_d;
    logic                 out_v_q, out_v_d;
    logic [1:0]           step;

    // Gray pair {B,A} to its position in the forward cycle 00,01,11,10.
    function automatic logic [1:0] gray_idx(input logic [1:0] g);
        return {g[1], g[1] ^ g[0]};
    endfunction

    assign sample_a = S_AXIS.tdata[HW-1:0];
    assign sample_b = S_AXIS.tdata[2*HW-1:HW];
    assign step     = gray_idx({bit_b_q, bit_a_q}) - gray_idx(prev_q);

    always_comb begin
        bit_a_d = bit_a_q;
        bit_b_d = bit_b_q;
        v1_d    = S_AXIS.tvalid;
        if (S_AXIS.tvalid) begin
            if (sample_a > upper_threshold)      bit_a_d = 1'b1;
            else if (sample_a < lower_threshold) bit_a_d = 1'b0;
            if (sample_b > upper_threshold)      bit_b_d = 1'b1;
            else if (sample_b < lower_threshold) bit_b_d = 1'b0;
        end
    end

    // step 01 = forward, 11 = reverse, 10 = illegal double change (position held).
    always_comb begin
        prev_d = prev_q;
        init_d = init_q;
        pos_d  = pos_q;
        v2_d   = v1_q;
        if (v1_q) begin
            prev_d = {bit_b_q, bit_a_q};
            init_d = 1'b1;
            if (init_q) begin
                case (step)
                    2'b01:   pos_d = pos_q + 1'b1;
                    2'b11:   pos_d = pos_q - 1'b1;
                    default: pos_d = pos_q;
                endcase
            end
        end
    end

    always_comb begin
        out_d   = out_q;
        out_v_d = v2_q;
        if (v2_q) out_d = $signed(pos_q) >>> log_scale;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            bit_a_q <= 1'b0;
            bit_b_q <= 1'b0;
            v1_q    <= 1'b0;
            prev_q  <= 2'b00;
            init_q  <= 1'b0;
            v2_q    <= 1'b0;
            pos_q   <= '0;
            out_q   <= '0;
            out_v_q <= 1'b0;
        end else begin
            bit_a_q <= bit_a_d;
            bit_b_q <= bit_b_d;
            v1_q    <= v1_d;
            prev_q  <= prev_d;
            init_q  <= init_d;
            v2_q    <= v2_d;
            pos_q   <= pos_d;
            out_q   <= out_d;
            out_v_q <= out_v_d;
        end
    end

    assign M_AXIS.tvalid = out_v_q;
    assign M_AXIS.tdata  = out_q;

`ifdef POSITION_TRACKER_ERROR_CNT_EN
    logic        illegal;
    logic [15:0] err_q, err_d;

    assign illegal = v1_q && init_q && (step == 2'b10);

    always_comb begin
        err_d = err_q;
        if (illegal && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
    end

    always_ff @(posedge aclk) begin
        if (areset) err_q <= 16'd0;
        else        err_q <= err_d;
    end

    assign error_count = err_q;
`endif
endmodule

// File: tb/tb_axis_position_tracker.sv
// Randomized and directed bench for axis_position_tracker with a queue-based scoreboard and a behavioural model.
`timescale 1ns/1ps
module tb_axis_position_tracker;
  localparam int SW = 32;
  localparam int MW = 32;

  logic               aclk = 1'b0;
  logic               areset;
  logic signed [15:0] lower_threshold;
  logic signed [15:0] upper_threshold;
  logic [4:0]         log_scale;
`ifdef POSITION_TRACKER_ERROR_CNT_EN
  logic [15:0]        error_count;
`endif

  axis_position_tracker_if #(.DATA_W(SW)) s_if ();
  axis_position_tracker_if #(.DATA_W(MW)) m_if ();

  axis_position_tracker #(
    .S_AXIS_TDATA_WIDTH(SW),
    .M_AXIS_TDATA_WIDTH(MW)
  ) dut (
    .aclk            (aclk),
    .areset          (areset),
    .lower_threshold (lower_threshold),
    .upper_threshold (upper_threshold),
    .log_scale       (log_scale),
    .S_AXIS          (s_if),
    .M_AXIS          (m_if)
`ifdef POSITION_TRACKER_ERROR_CNT_EN
    ,
    .error_count     (error_count)
`endif
  );

  // clock / reset
  always #5 aclk = ~aclk;

  int          total = 0;
  int          bad = 0;
  logic [MW-1:0] exp_q[$];

  // behavioural model state
  bit          m_a, m_b, m_init;
  logic [1:0]  m_prev;
  logic [31:0] m_pos;
  int          m_err;
  int          q_phase;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // position of a {B,A} pair within the forward cycle 00 -> 01 -> 11 -> 10
  function automatic int ring_pos(input bit b, input bit a);
    case ({b, a})
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  // floor(pos / 2^ls) on the signed value
  function automatic logic [31:0] scaled(input logic [31:0] pos, input int ls);
    longint p, d, q;
    logic [63:0] t;
    p = longint'($signed(pos));
    d = longint'(1) << ls;
    q = (p >= 0) ? p / d : -((-p + d - 1) / d);
    t = q;
    return t[31:0];
  endfunction

  function automatic void model_reset();
    m_a = 0; m_b = 0; m_init = 0; m_prev = 2'b00; m_pos = 32'd0; m_err = 0;
  endfunction

  function automatic void model_beat(input int a, input int b);
    int d;
    if (a > int'(upper_threshold)) m_a = 1; else if (a < int'(lower_threshold)) m_a = 0;
    if (b > int'(upper_threshold)) m_b = 1; else if (b < int'(lower_threshold)) m_b = 0;
    if (m_init) begin
      d = (ring_pos(m_b, m_a) - ring_pos(m_prev[1], m_prev[0]) + 4) % 4;
      if (d == 1) m_pos = m_pos + 32'd1;
      else if (d == 3) m_pos = m_pos - 32'd1;
      else if (d == 2 && m_err < 65535) m_err++;
    end
    m_init = 1;
    m_prev = {m_b, m_a};
    exp_q.push_back(scaled(m_pos, int'(log_scale)));
  endfunction

  // driver tasks
  task automatic send(input int a, input int b);
    s_if.tvalid = 1'b1;
    s_if.tdata  = {16'(b), 16'(a)};
    if (!areset) model_beat(a, b);
    @(posedge aclk); #1;
  endtask

  task automatic idle(input int n);
    s_if.tvalid = 1'b0;
    s_if.tdata  = $urandom;
    repeat (n) begin @(posedge aclk); #1; end
  endtask

  task automatic flush();
    int n;
    n = 0;
    s_if.tvalid = 1'b0;
    while (exp_q.size() != 0 && n < 20) begin @(posedge aclk); #1; n++; end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL flush: outstanding=%0d required=0", exp_q.size());
    end
    repeat (2) @(posedge aclk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge aclk); #1;
    areset = 1'b1;
    exp_q.delete();
    model_reset();
    repeat (cycles) begin
      @(posedge aclk); #1;
      check("reset_tvalid", 32'(m_if.tvalid), 32'd0);
      check("reset_tdata", m_if.tdata, 32'd0);
    end
    areset = 1'b0;
  endtask

  task automatic quad(input int n, input bit fwd);
    int reps;
    for (int i = 0; i < n; i++) begin
      q_phase = fwd ? (q_phase + 1) % 4 : (q_phase + 3) % 4;
      reps = $urandom_range(1, 3);
      for (int r = 0; r < reps; r++) begin
        case (q_phase)
          0: send(-15, -15);
          1: send(15, -15);
          2: send(15, 15);
          default: send(-15, 15);
        endcase
      end
    end
  endtask

  // scoreboard monitor
  initial begin
    forever begin
      @(negedge aclk);
      if (m_if.tvalid === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got %h expected no beat", m_if.tdata);
        end else begin
          check("m_axis_tdata", m_if.tdata, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int v, a, b, ls;
    areset = 1'b0;
    lower_threshold = -16'sd1;
    upper_threshold = 16'sd1;
    log_scale = 5'd0;
    s_if.tvalid = 1'b1;
    s_if.tdata = {16'sd15, 16'sd0};
    model_reset();

    // reset with valid input, then three edges of latency; first output is 0
    do_reset(2);
    for (int e = 1; e <= 3; e++) begin
      send(0, 15);
      check("latency_tvalid", 32'(m_if.tvalid), (e == 3) ? 32'd1 : 32'd0);
    end
    check("first_output", m_if.tdata, 32'd0);

    // single-channel dither, B falls at beat 80
    for (int i = 0; i < 200; i++) begin
      v = i % 20;
      a = (v <= 10) ? 15 - 3 * v : -15 + 3 * (v - 10);
      send(a, (i < 80) ? 15 : -15);
    end
    flush();

    // hysteresis hold with strict compares
    do_reset(1);
    send(-15, -15);
    send(0, -15); send(1, -15); send(0, -15); send(-1, -15);
    flush();
    check("hysteresis_hold", m_if.tdata, 32'd0);

    // quadrature forward then reverse
    q_phase = 0;
    quad(20, 1'b1);
    flush();
    check("quad_forward", m_if.tdata, 32'd20);
    quad(20, 1'b0);
    flush();
    check("quad_reverse", m_if.tdata, 32'd0);

    // illegal double changes 00 -> 11 -> 00
    send(15, 15);
    flush();
    check("illegal_hold", m_if.tdata, 32'd0);
`ifdef POSITION_TRACKER_ERROR_CNT_EN
    check("error_count_1", 32'(error_count), 32'd1);
`endif
    send(-15, -15);
    flush();
`ifdef POSITION_TRACKER_ERROR_CNT_EN
    check("error_count_2", 32'(error_count), 32'd2);
`endif

    // scaling
    log_scale = 5'd2;
    do_reset(1);
    q_phase = 0;
    send(-15, -15);
    quad(8, 1'b1);
    flush();
    check("scale_8_by_4", m_if.tdata, 32'd2);
    log_scale = 5'd1;
    do_reset(1);
    q_phase = 0;
    send(-15, -15);
    quad(5, 1'b0);
    flush();
    check("scale_m5_by_2", m_if.tdata, 32'hFFFF_FFFD);

    // wrap at the signed maximum
    log_scale = 5'd0;
    do_reset(1);
    q_phase = 0;
    send(-15, -15);
    flush();
    @(negedge aclk);
    force dut.pos_q = 32'h7FFF_FFFE;
    @(posedge aclk); #1;
    release dut.pos_q;
    m_pos = 32'h7FFF_FFFE;
    quad(2, 1'b1);
    flush();
    check("wrap", m_if.tdata, 32'h8000_0000);

    // randomized stream with live thresholds, gaps and one mid-stream reset
    do_reset(1);
    for (int i = 0; i < 400; i++) begin
      if (i % 100 == 0) begin
        flush();
        ls = $urandom_range(0, 6);
        if (i == 200) ls = 31;
        log_scale = 5'(ls);
      end
      if (i == 150) begin
        s_if.tvalid = 1'($urandom_range(0, 1));
        do_reset(1);
      end
      if ($urandom_range(0, 19) == 0) begin
        lower_threshold = 16'(-int'($urandom_range(0, 8)));
        upper_threshold = 16'($urandom_range(0, 8));
      end
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
      else send(int'($urandom_range(0, 40)) - 20, int'($urandom_range(0, 40)) - 20);
    end
    flush();
`ifdef POSITION_TRACKER_ERROR_CNT_EN
    check("error_count_random", 32'(error_count), 32'(m_err));
`endif
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global time limit
  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
